// File: rtl/reg_bank_dbg.sv
// Two-read/one-write register bank with optional r0 hardwiring and write bypass,
// plus a handshaked debug port that streams every register out in index order.
module reg_bank_dbg #(
  parameter int unsigned WIDTH_B = 32,
  parameter int unsigned ADDR_B  = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RegWrite,
  input  logic [ADDR_B-1:0]  Write_Addr,
  input  logic [WIDTH_B-1:0] Write_Data,
  input  logic [ADDR_B-1:0]  Read_Addr_1,
  input  logic [ADDR_B-1:0]  Read_Addr_2,
  output logic [WIDTH_B-1:0] Read_Data_1,
  output logic [WIDTH_B-1:0] Read_Data_2,
  input  logic               dbg_start,
  output logic               dbg_valid,
  input  logic               dbg_ready,
  output logic [ADDR_B-1:0]  dbg_addr,
  output logic [WIDTH_B-1:0] dbg_data,
  output logic               dbg_busy,
  output logic               dbg_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_B;
  localparam logic [ADDR_B-1:0] LAST_ADDR = ADDR_B'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [WIDTH_B-1:0] regs [DEPTH];
  logic               we_c;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               valid_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [ADDR_B-1:0]  addr_nxt;
  logic [WIDTH_B-1:0] data_nxt;

  logic [ADDR_B-1:0]  next_idx;
  logic [WIDTH_B-1:0] rd_first;
  logic [WIDTH_B-1:0] rd_next;

  // Value any reader sees for addr this cycle: r0 forcing, then write forwarding.
  function automatic logic [WIDTH_B-1:0] read_val(
    input logic [ADDR_B-1:0]  addr,
    input logic [WIDTH_B-1:0] stored,
    input logic               we,
    input logic [ADDR_B-1:0]  waddr,
    input logic [WIDTH_B-1:0] wdata
  );
    logic [WIDTH_B-1:0] val;
    val = stored;
    if (BYPASS && we && (waddr == addr)) begin
      val = wdata;
    end
    if (ZERO_R0 && (addr == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  assign we_c = RegWrite && !(ZERO_R0 && (Write_Addr == '0));

  // Register array; writes to r0 are dropped when it is hardwired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (we_c) begin
      regs[Write_Addr] <= Write_Data;
    end
  end

  assign Read_Data_1 = read_val(Read_Addr_1, regs[Read_Addr_1], we_c, Write_Addr, Write_Data);
  assign Read_Data_2 = read_val(Read_Addr_2, regs[Read_Addr_2], we_c, Write_Addr, Write_Data);

  assign next_idx = dbg_addr + ADDR_B'(1);
  assign rd_first = read_val('0, regs[0], we_c, Write_Addr, Write_Data);
  assign rd_next  = read_val(next_idx, regs[next_idx], we_c, Write_Addr, Write_Data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dump sequencing; the presented beat only changes when it is accepted.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    addr_nxt  = dbg_addr;
    data_nxt  = dbg_data;
    case (state)
      S_IDLE: begin
        if (dbg_start) begin
          state_nxt = S_SEND;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          addr_nxt  = '0;
          data_nxt  = rd_first;
        end
      end
      S_SEND: begin
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
        if (dbg_ready) begin
          if (dbg_addr == LAST_ADDR) begin
            state_nxt = S_DONE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = next_idx;
            data_nxt = rd_next;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_valid <= 1'b0;
      dbg_busy  <= 1'b0;
      dbg_done  <= 1'b0;
      dbg_addr  <= '0;
      dbg_data  <= '0;
    end else begin
      dbg_valid <= valid_nxt;
      dbg_busy  <= busy_nxt;
      dbg_done  <= done_nxt;
      dbg_addr  <= addr_nxt;
      dbg_data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bank_dbg.sv
// Directed bench for reg_bank_dbg: default build plus a no-bypass, writable-r0 build.
module tb_reg_bank_dbg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  Write_Addr;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Addr_1;
  logic [4:0]  Read_Addr_2;
  logic [31:0] Read_Data_1;
  logic [31:0] Read_Data_2;
  logic        dbg_start;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_busy;
  logic        dbg_done;

  logic [31:0] alt_rd1;
  logic [31:0] alt_rd2;
  logic        alt_valid;
  logic [4:0]  alt_addr;
  logic [31:0] alt_data;
  logic        alt_busy;
  logic        alt_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_dbg dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .Write_Addr(Write_Addr),
    .Write_Data(Write_Data), .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2),
    .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2), .dbg_start(dbg_start),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
  );

  reg_bank_dbg #(.ZERO_R0(1'b0), .BYPASS(1'b0)) alt (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .Write_Addr(Write_Addr),
    .Write_Data(Write_Data), .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2),
    .Read_Data_1(alt_rd1), .Read_Data_2(alt_rd2), .dbg_start(dbg_start),
    .dbg_valid(alt_valid), .dbg_ready(dbg_ready), .dbg_addr(alt_addr),
    .dbg_data(alt_data), .dbg_busy(alt_busy), .dbg_done(alt_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [31:0] exp_data);
    chk({tag, "_valid"}, 32'(dbg_valid), 32'd1);
    chk({tag, "_busy"},  32'(dbg_busy),  32'd1);
    chk({tag, "_addr"},  32'(dbg_addr),  32'(idx));
    chk({tag, "_data"},  dbg_data,       exp_data);
  endtask

  initial begin
    rst_n = 1'b0; RegWrite = 1'b0; Write_Addr = '0; Write_Data = '0;
    Read_Addr_1 = '0; Read_Addr_2 = '0; dbg_start = 1'b0; dbg_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(dbg_valid), 32'd0);
    chk("rst_busy",  32'(dbg_busy),  32'd0);
    chk("rst_done",  32'(dbg_done),  32'd0);
    chk("rst_addr",  32'(dbg_addr),  32'd0);
    chk("rst_data",  dbg_data,       32'd0);
    rst_n = 1'b1;
    tick();

    // All registers read back zero on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      Read_Addr_1 = 5'(i);
      Read_Addr_2 = 5'(31 - i);
      #1;
      chk("rst_rd1", Read_Data_1, 32'd0);
      chk("rst_rd2", Read_Data_2, 32'd0);
    end
    tick();

    // Same-cycle forwarding versus pre-write value.
    RegWrite = 1'b1; Write_Addr = 5'd5; Write_Data = 32'hDEADBEEF; Read_Addr_1 = 5'd5;
    #1;
    chk("byp_on",  Read_Data_1, 32'hDEADBEEF);
    chk("byp_off", alt_rd1,     32'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    chk("r5_on",  Read_Data_1, 32'hDEADBEEF);
    chk("r5_off", alt_rd1,     32'hDEADBEEF);

    // Write to r0.
    RegWrite = 1'b1; Write_Addr = 5'd0; Write_Data = 32'h1234;
    Read_Addr_1 = 5'd0; Read_Addr_2 = 5'd0;
    #1;
    chk("r0_same_rd1", Read_Data_1, 32'd0);
    chk("r0_same_rd2", Read_Data_2, 32'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    chk("r0_z_rd1",  Read_Data_1, 32'd0);
    chk("r0_z_rd2",  Read_Data_2, 32'd0);
    chk("r0_nz_rd1", alt_rd1,     32'h1234);
    chk("r0_nz_rd2", alt_rd2,     32'h1234);

    // Load rN = N + 100.
    for (int n = 1; n < 32; n++) begin
      RegWrite = 1'b1; Write_Addr = 5'(n); Write_Data = 32'(n + 100);
      tick();
    end
    RegWrite = 1'b0;
    Read_Addr_1 = 5'd17;
    #1;
    chk("load_r17", Read_Data_1, 32'd117);

    // Full dump with ready held high; a stray start mid-dump is ignored.
    dbg_ready = 1'b1; dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk_beat("dump", i, (i == 0) ? 32'd0 : 32'(i + 100));
      dbg_start = (i == 10 || i == 11);
      tick();
    end
    dbg_start = 1'b0;
    chk("dump_end_valid", 32'(dbg_valid), 32'd0);
    chk("dump_end_done",  32'(dbg_done),  32'd1);
    chk("dump_end_busy",  32'(dbg_busy),  32'd1);
    tick();
    chk("post_done", 32'(dbg_done), 32'd0);
    chk("post_busy", 32'(dbg_busy), 32'd0);
    tick();
    chk("no_queue_busy",  32'(dbg_busy),  32'd0);
    chk("no_queue_valid", 32'(dbg_valid), 32'd0);

    // Stall at beat 7 while r7 is overwritten.
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_beat("pre_stall", i, (i == 0) ? 32'd0 : 32'(i + 100));
      tick();
    end
    dbg_ready = 1'b0;
    RegWrite = 1'b1; Write_Addr = 5'd7; Write_Data = 32'hAA;
    for (int c = 0; c < 3; c++) begin
      chk_beat("stall", 7, 32'd107);
      tick();
    end
    RegWrite = 1'b0;
    dbg_ready = 1'b1;
    Read_Addr_1 = 5'd7;
    #1;
    chk("r7_written", Read_Data_1, 32'hAA);
    chk_beat("stall_release", 7, 32'd107);
    tick();
    for (int i = 8; i < 32; i++) begin
      chk_beat("post_stall", i, 32'(i + 100));
      tick();
    end
    chk("stall_dump_done", 32'(dbg_done), 32'd1);
    tick();
    tick();

    // Reset in the middle of a dump.
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
    end
    chk_beat("pre_rst", 12, 32'd112);
    rst_n = 1'b0;
    RegWrite = 1'b1; Write_Addr = 5'd9; Write_Data = 32'h5555;
    #1;
    chk("mid_rst_valid", 32'(dbg_valid), 32'd0);
    chk("mid_rst_busy",  32'(dbg_busy),  32'd0);
    chk("mid_rst_done",  32'(dbg_done),  32'd0);
    chk("mid_rst_addr",  32'(dbg_addr),  32'd0);
    chk("mid_rst_data",  dbg_data,       32'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      Read_Addr_1 = 5'(i);
      #1;
      chk("mid_rst_clear", Read_Data_1, 32'd0);
    end
    tick();
    chk("after_rst_done", 32'(dbg_done), 32'd0);
    chk("after_rst_busy", 32'(dbg_busy), 32'd0);
    tick();
    chk("after_rst_idle", 32'(dbg_valid), 32'd0);
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    chk_beat("restart", 0, 32'd0);
    tick();
    chk_beat("restart", 1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_dbg.md
REG_BANK_DBG -- requirements
Module: reg_bank_dbg

Interface
REQ-001 SHALL have parameter WIDTH_B, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_B, default 5, address width; depth DEPTH = 2**ADDR_B.
REQ-003 SHALL have parameter ZERO_R0, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write data is forwarded to the read ports when 1.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have ports RegWrite (in, 1), Write_Addr (in, ADDR_B) and Write_Data (in, WIDTH_B): the write enable, target address and write data.
REQ-008 SHALL have ports Read_Addr_1 and Read_Addr_2 (in, ADDR_B each) and Read_Data_1 and Read_Data_2 (out, WIDTH_B each): two combinational read ports.
REQ-009 SHALL have port dbg_start, input, 1 bit, a request to dump all registers.
REQ-010 SHALL have ports dbg_valid (out, 1), dbg_ready (in, 1), dbg_addr (out, ADDR_B) and dbg_data (out, WIDTH_B): the dump stream handshake, register index and register value.
REQ-011 SHALL have ports dbg_busy (out, 1) and dbg_done (out, 1): dump in progress, and a one-cycle end-of-dump pulse.

Function
REQ-012 SHALL write Write_Data into register Write_Addr on the rising clk edge when RegWrite=1.
REQ-013 SHALL, when ZERO_R0=1, discard any write to address 0 and return 0 on every read of address 0, including read ports, bypass and dump.
REQ-014 SHALL drive Read_Data_n combinationally from the array contents at Read_Addr_n.
REQ-015 SHALL, when BYPASS=1, RegWrite=1 and Write_Addr==Read_Addr_n (nonzero when ZERO_R0=1), drive Read_Data_n = Write_Data in the same cycle.
REQ-016 SHALL, when BYPASS=0, return the pre-write value during the write cycle.
REQ-017 SHALL implement the dump FSM with states IDLE, SEND and DONE.
REQ-018 SHALL, in IDLE with dbg_start=1, move to SEND on the next edge, setting dbg_addr=0 and dbg_data to the value read port logic returns for address 0 in that cycle.
REQ-019 SHALL, in SEND, hold dbg_valid=1; dbg_addr and dbg_data are registered and SHALL stay stable while dbg_ready=0, even if the presented register is written.
REQ-020 SHALL, in SEND with dbg_ready=1 and dbg_addr<DEPTH-1, set dbg_addr to dbg_addr+1 and load dbg_data with that address's read-port-equivalent value in the same cycle (bypass per REQ-015), so back-to-back beats run at one per cycle.
REQ-021 SHALL, in SEND with dbg_ready=1 and dbg_addr==DEPTH-1, move to DONE; dbg_valid=0 in DONE.
REQ-022 SHALL, in DONE, assert dbg_done=1 for exactly one cycle and then return to IDLE.
REQ-023 SHALL drive dbg_busy=1 in SEND and DONE, and 0 in IDLE.
REQ-024 SHALL ignore dbg_start outside IDLE and never queue it.
REQ-025 SHALL keep normal reads and writes fully functional during a dump, with no stall and no priority between dump and write.
REQ-026 SHALL keep dbg_addr from wrapping; DEPTH beats exactly per dump.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all DEPTH registers to 0, force the FSM to IDLE, and drive dbg_valid=0, dbg_busy=0, dbg_done=0, dbg_addr=0 and dbg_data=0.
REQ-028 SHALL abort a dump on reset mid-dump with no dbg_done pulse; after release a new dbg_start SHALL be required.
REQ-029 SHALL ignore RegWrite while rst_n=0.

Verification
REQ-030 SHALL cover reset then read of all 32 addresses on both ports -> all 0.
REQ-031 SHALL cover write 0xDEADBEEF to r5 with Read_Addr_1=5 in the same cycle -> Read_Data_1=0xDEADBEEF with BYPASS=1, and 0 with BYPASS=0; the next cycle -> 0xDEADBEEF in both cases.
REQ-032 SHALL cover write 0x1234 to r0 -> Read_Data_1 and Read_Data_2 at address 0 both 0 with ZERO_R0=1, and 0x1234 with ZERO_R0=0.
REQ-033 SHALL cover loading rN=N+100, then dbg_start with dbg_ready=1 constantly -> 32 consecutive beats, dbg_addr 0..31, dbg_data 0 then 101..131, then one dbg_done pulse and dbg_busy=0 the next cycle.
REQ-034 SHALL cover dump with dbg_ready=0 for 3 cycles at dbg_addr=7 while r7 is written to 0xAA -> dbg_data holds the old value 107 throughout the stall; after the stall, beat 8 = 108.
REQ-035 SHALL cover rst_n pulsed low at dbg_addr=12 -> dbg_valid=0 and dbg_busy=0 immediately with no dbg_done, all registers 0, and a fresh dbg_start restarting the dump at dbg_addr=0.
